// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch front end for the pipelined MIPS core. It owns the fetch
// PC, issues word requests to a possibly stalling instruction memory, buffers
// returned words with their PC in a small FIFO, and hands them to decode over
// a valid/ready handshake. A redirect from downstream flushes the buffer and
// restarts fetch at the new target.
//
// Parameters
//   RESET_PC     fetch address after reset
//   DEPTH        prefetch FIFO entries (power of two, 2..8)
//
// Ports
//   clk          single clock, all state on rising edge
//   reset        synchronous, active-high
//   imem_req     fetch request to instruction memory
//   imem_addr    word-aligned fetch address (always fetch_pc)
//   imem_ack     memory accepts request and returns data this cycle
//   imem_rdata   instruction word, valid when imem_req && imem_ack
//   redirect     flush and restart fetch (taken branch/jump)
//   redirect_pc  new fetch target, bits [1:0] ignored
//   out_valid    FIFO head holds a valid instruction
//   out_ready    decode accepts head this cycle
//   out_instr    head instruction
//   out_pc       PC of head instruction
//   out_pc_plus4 out_pc + 4, modulo 2^32
//
// States
//   state   | meaning
//   FETCH   | normal fetching; request issued while FIFO has room
//   DISCARD | redirect arrived while a request was stalled; hold that request
//           | until it is acked, drop its data, then restart at pending_pc
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [0:0] FETCH   = 1'b0;
  localparam logic [0:0] DISCARD = 1'b1;

  logic [0:0]       state;
  logic [31:0]      fetch_pc;
  logic [31:0]      pending_pc;
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic        fire;
  logic        push;
  logic        pop;
  logic [31:0] target_pc;
  logic [31:0] head_instr;
  logic [31:0] head_pc;
  logic        unused_rpc_bits;

  assign target_pc       = {redirect_pc[31:2], 2'b00};
  assign unused_rpc_bits = ^redirect_pc[1:0];

  // Request depends on registered state only, so it stays stable across a
  // stalled transfer even when redirect toggles.
  assign imem_req  = !reset &&
                     (((state == FETCH) && (count < FULL_CNT)) || (state == DISCARD));
  assign imem_addr = fetch_pc;

  assign fire = imem_req && imem_ack;
  // Acked data is only kept in FETCH without a same-cycle redirect.
  assign push = fire && (state == FETCH) && !redirect;

  assign head_instr = instr_q[rd_ptr];
  assign head_pc    = pc_q[rd_ptr];

  // Outputs are forced to the cleared-entry values while reset is held so
  // the reset cycle itself already presents an empty, zeroed head.
  assign out_valid    = !reset && (count != '0);
  assign out_instr    = reset ? 32'h0 : head_instr;
  assign out_pc       = reset ? 32'h0 : head_pc;
  assign out_pc_plus4 = out_pc + 32'd4;

  assign pop = out_valid && out_ready;

  // Fetch PC / FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      pending_pc <= 32'h0;
    end else if (state == FETCH) begin
      if (redirect) begin
        if (imem_req && !imem_ack) begin
          // The memory still owns the old address; wait it out.
          state      <= DISCARD;
          pending_pc <= target_pc;
        end else begin
          fetch_pc <= target_pc;
        end
      end else if (fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end else begin
      if (redirect) begin
        pending_pc <= target_pc;
      end
      if (imem_ack) begin
        fetch_pc <= redirect ? target_pc : pending_pc;
        state    <= FETCH;
      end
    end
  end

  // Prefetch FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 32'h0;
        pc_q[i]    <= 32'h0;
      end
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= imem_rdata;
        pc_q[wr_ptr]    <= fetch_pc;
      end
      if (redirect) begin
        // A same-cycle pop has already been consumed by decode; nothing
        // survives the flush either way.
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed bench for if_fetch_unit. A queue-based model predicts the memory
// request and the FIFO head every cycle; literal checks in the stimulus pin
// the model at the interesting points (reset, stall, redirect, wrap).
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic        redirect = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic        out_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_rdata = word_at(imem_addr);

  if_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc   = RST_PC;
  logic [31:0] m_pend = 32'h0;
  bit          m_disc = 1'b0;
  bit          m_req;
  bit          m_fire;
  logic [31:0] m_tgt;
  ent_t        m_ent;

  always @(posedge clk) begin
    m_req  = !reset && (m_disc || q.size() < DEPTH);
    m_fire = m_req && imem_ack;
    m_tgt  = {redirect_pc[31:2], 2'b00};
    if (reset) begin
      q.delete();
      m_pc   = RST_PC;
      m_pend = 32'h0;
      m_disc = 1'b0;
    end else begin
      if (q.size() != 0 && out_ready) q.delete(0);
      if (redirect) q.delete();
      if (m_disc) begin
        if (redirect) m_pend = m_tgt;
        if (m_fire) begin
          m_pc   = m_pend;
          m_disc = 1'b0;
        end
      end else if (redirect) begin
        if (m_req && !imem_ack) begin
          m_disc = 1'b1;
          m_pend = m_tgt;
        end else begin
          m_pc = m_tgt;
        end
      end else if (m_fire) begin
        m_ent.instr = word_at(m_pc);
        m_ent.pc    = m_pc;
        q.push_back(m_ent);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit e_req;
  bit e_valid;

  always @(negedge clk) begin
    e_req   = !reset && (m_disc || q.size() < DEPTH);
    e_valid = !reset && q.size() != 0;
    chk1("m_imem_req", imem_req, e_req);
    if (e_req) chk("m_imem_addr", imem_addr, m_pc);
    chk1("m_out_valid", out_valid, e_valid);
    if (e_valid) begin
      chk("m_out_instr", out_instr, q[0].instr);
      chk("m_out_pc", out_pc, q[0].pc);
      chk("m_out_pc_plus4", out_pc_plus4, q[0].pc + 32'd4);
    end
  end

  // One cycle: drive inputs just after the rising edge, return mid-cycle.
  task automatic cyc(input logic rst, input logic ack, input logic rd,
                     input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    reset       = rst;
    imem_ack    = ack;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    @(negedge clk);
  endtask

  initial begin
    // Reset, then zero-wait streaming from RESET_PC
    cyc(1, 1, 0, 32'h0, 1);
    cyc(1, 1, 0, 32'h0, 1);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", out_valid, 1'b0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_pc4", out_pc_plus4, 32'h4);
    cyc(0, 1, 0, 32'h0, 1);
    chk1("s_req0", imem_req, 1'b1);
    chk("s_addr0", imem_addr, 32'h0040_0000);
    chk1("s_valid0", out_valid, 1'b0);
    cyc(0, 1, 0, 32'h0, 1);
    chk("s_addr1", imem_addr, 32'h0040_0004);
    chk1("s_valid1", out_valid, 1'b1);
    chk("s_pc1", out_pc, 32'h0040_0000);
    chk("s_instr1", out_instr, 32'hDEED_BEEF);
    cyc(0, 1, 0, 32'h0, 1);
    chk("s_addr2", imem_addr, 32'h0040_0008);
    chk("s_pc2", out_pc, 32'h0040_0004);
    repeat (3) cyc(0, 1, 0, 32'h0, 1);

    // Back-pressure: fill to DEPTH, stall, drain in order
    cyc(0, 1, 1, 32'h0, 1);
    cyc(0, 1, 0, 32'h0, 0);
    chk("bp_addr0", imem_addr, 32'h0);
    chk1("bp_valid0", out_valid, 1'b0);
    repeat (3) cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 1, 0, 32'h0, 0);
    chk1("bp_req_full", imem_req, 1'b0);
    chk("bp_head", out_pc, 32'h0);
    repeat (5) cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 1, 0, 32'h0, 1);
    chk1("bp_req_pop", imem_req, 1'b0);
    chk("bp_d0", out_pc, 32'h0);
    cyc(0, 1, 0, 32'h0, 1);
    chk1("bp_req_again", imem_req, 1'b1);
    chk("bp_resume", imem_addr, 32'h10);
    chk("bp_d1", out_pc, 32'h4);
    cyc(0, 1, 0, 32'h0, 1);
    chk("bp_d2", out_pc, 32'h8);
    cyc(0, 1, 0, 32'h0, 1);
    chk("bp_d3", out_pc, 32'hC);
    cyc(0, 1, 0, 32'h0, 1);
    chk("bp_d4", out_pc, 32'h10);

    // Slow memory, redirect during stalled request -> DISCARD
    cyc(0, 1, 1, 32'h20, 1);
    for (int k = 0; k < 9; k++) begin
      cyc(0, (k % 3) == 2, k == 1, 32'h0000_0103, 1);
      if (k <= 2) chk("ds_hold", imem_addr, 32'h20);
      if (k == 2) chk1("ds_req", imem_req, 1'b1);
      if (k == 3) chk("ds_new", imem_addr, 32'h100);
      if (k == 3 || k == 4) chk1("ds_empty", out_valid, 1'b0);
      if (k == 6) begin
        chk1("ds_valid", out_valid, 1'b1);
        chk("ds_pc", out_pc, 32'h100);
        chk("ds_addr", imem_addr, 32'h104);
      end
    end

    // Redirect in the same cycle as an ack and a pop
    cyc(0, 1, 1, 32'h0, 1);
    cyc(0, 1, 0, 32'h0, 1);
    cyc(0, 1, 0, 32'h0, 1);
    cyc(0, 1, 1, 32'h200, 1);
    chk("ra_addr", imem_addr, 32'h8);
    chk("ra_head", out_pc, 32'h4);
    cyc(0, 1, 0, 32'h0, 1);
    chk1("ra_empty", out_valid, 1'b0);
    chk("ra_target", imem_addr, 32'h200);
    cyc(0, 1, 0, 32'h0, 1);
    chk("ra_first", out_pc, 32'h200);

    // Reset with 3 entries and a stalled request, then reset in DISCARD
    cyc(0, 1, 1, 32'h0, 0);
    repeat (3) cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    chk1("r3_valid", out_valid, 1'b1);
    chk("r3_addr", imem_addr, 32'hC);
    cyc(1, 0, 0, 32'h0, 0);
    chk1("r3_rvalid", out_valid, 1'b0);
    chk1("r3_rreq", imem_req, 1'b0);
    chk("r3_rinstr", out_instr, 32'h0);
    cyc(1, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    chk("r3_restart", imem_addr, 32'h0040_0000);
    chk1("r3_empty", out_valid, 1'b0);
    cyc(0, 0, 1, 32'h600, 0);
    cyc(0, 0, 0, 32'h0, 0);
    chk("rd_hold", imem_addr, 32'h0040_0000);
    cyc(1, 0, 0, 32'h0, 0);
    chk1("rd_rreq", imem_req, 1'b0);
    cyc(0, 1, 0, 32'h0, 1);
    chk("rd_restart", imem_addr, 32'h0040_0000);
    chk1("rd_empty", out_valid, 1'b0);
    cyc(0, 1, 0, 32'h0, 1);
    chk("rd_first", out_pc, 32'h0040_0000);

    // DISCARD: latest redirect wins; redirect on the discard ack wins too
    cyc(0, 0, 1, 32'h700, 1);
    cyc(0, 0, 1, 32'h800, 1);
    cyc(0, 1, 0, 32'h0, 1);
    cyc(0, 0, 1, 32'h900, 1);
    chk("lw_addr", imem_addr, 32'h800);
    cyc(0, 1, 1, 32'hA07, 1);
    cyc(0, 1, 0, 32'h0, 1);
    chk("lw_ack_redir", imem_addr, 32'hA04);

    // PC wrap at 2^32
    cyc(0, 1, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 1, 0, 32'h0, 1);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 32'h0, 1);
    chk("wr_pc", out_pc, 32'hFFFF_FFFC);
    chk("wr_pc4", out_pc_plus4, 32'h0);
    chk("wr_instr", out_instr, 32'h2152_4113);
    chk("wr_next", imem_addr, 32'h0);
    cyc(0, 1, 0, 32'h0, 1);
    chk("wr_pc0", out_pc, 32'h0);

    repeat (3) cyc(0, 1, 0, 32'h0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
